// File: rtl/dna_matrix_reader_if.sv
// Matrix-memory read port plus the 32-bit score stream toward the host side.
// master = reader (drives the read strobe and stream), slave = memory/consumer side.
interface dna_matrix_reader_if;
  logic         mem_rd_o;
  logic [31:0]  mem_addr_o;
  logic [511:0] mem_row_i;
  logic [31:0]  out_data_o;
  logic         out_valid_o;
  logic         out_ready_i;
  logic         out_last_o;

  modport master (
    output mem_rd_o, mem_addr_o, out_data_o, out_valid_o, out_last_o,
    input  mem_row_i, out_ready_i
  );

  modport slave (
    input  mem_rd_o, mem_addr_o, out_data_o, out_valid_o, out_last_o,
    output mem_row_i, out_ready_i
  );
endinterface

// File: rtl/dna_matrix_reader.sv
// Reads score-matrix rows and streams them word by word while tracking the signed max; 18 cycles/row.
// The stream stalls on out_ready_i=0 with data held; the next row is fetched only after word 15 is accepted.
module dna_matrix_reader #(
  parameter int unsigned addr_start_matrix = 0,
  parameter int unsigned addr_end_matrix   = 30,
  parameter int unsigned ROW_WORDS         = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  dna_matrix_reader_if.master  bus,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [31:0]          max_score_o,
  output logic [31:0]          max_row_o,
  output logic [3:0]           max_col_o
);

  localparam logic [31:0] ADDR_FIRST = 32'(addr_start_matrix);
  localparam logic [31:0] ADDR_LAST  = 32'(addr_end_matrix);
  localparam logic [31:0] MAX_INIT   = 32'h8000_0000;

  if (addr_end_matrix < addr_start_matrix) begin : g_range_chk
    $error("dna_matrix_reader: addr_end_matrix must be >= addr_start_matrix");
  end
  if (ROW_WORDS != 16) begin : g_width_chk
    $error("dna_matrix_reader: ROW_WORDS is fixed at 16");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_SEND,
    S_DONE
  } state_t;

  state_t       state_q;
  state_t       state_d;
  logic [31:0]  addr_q;
  logic [511:0] row_buf_q;
  logic [3:0]   idx_q;
  logic [31:0]  max_score_q;
  logic [31:0]  max_row_q;
  logic [3:0]   max_col_q;

  logic [31:0]  word_cur;
  logic         hs;
  logic         row_end;
  logic         last_row;

  assign word_cur = row_buf_q[{idx_q, 5'd0} +: 32];
  assign hs       = (state_q == S_SEND) && bus.out_ready_i;
  assign row_end  = (idx_q == 4'hF);
  assign last_row = (addr_q == ADDR_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start_i) state_d = S_REQ;
      S_REQ:  state_d = S_WAIT;
      S_WAIT: state_d = S_SEND;
      S_SEND: begin
        if (hs && row_end) begin
          state_d = last_row ? S_DONE : S_REQ;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q      <= ADDR_FIRST;
      row_buf_q   <= '0;
      idx_q       <= '0;
      max_score_q <= MAX_INIT;
      max_row_q   <= '0;
      max_col_q   <= '0;
    end else begin
      if (state_q == S_IDLE && start_i) begin
        addr_q      <= ADDR_FIRST;
        max_score_q <= MAX_INIT;
        max_row_q   <= '0;
        max_col_q   <= '0;
      end
      if (state_q == S_WAIT) begin
        row_buf_q <= bus.mem_row_i;
        idx_q     <= '0;
      end
      if (hs) begin
        idx_q <= idx_q + 4'd1;
        if (row_end && !last_row) begin
          addr_q <= addr_q + 32'd1;
        end
        // Strict compare so equal scores keep the earliest position.
        if ($signed(word_cur) > $signed(max_score_q)) begin
          max_score_q <= word_cur;
          max_row_q   <= addr_q;
          max_col_q   <= idx_q;
        end
      end
    end
  end

  assign bus.mem_rd_o    = (state_q == S_REQ);
  assign bus.mem_addr_o  = addr_q;
  assign bus.out_valid_o = (state_q == S_SEND);
  assign bus.out_data_o  = (state_q == S_SEND) ? word_cur : 32'd0;
  assign bus.out_last_o  = (state_q == S_SEND) && row_end && last_row;

  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = (state_q == S_DONE);
  assign max_score_o = max_score_q;
  assign max_row_o   = max_row_q;
  assign max_col_o   = max_col_q;

endmodule

// File: tb/tb_dna_matrix_reader.sv
// Directed readout scenarios with randomized data/backpressure, checked against a row-major reference model.
module tb_dna_matrix_reader;

  localparam int START = 0;
  localparam int END   = 30;
  localparam int N     = END - START + 1;
  localparam int WORDS = N * 16;
  localparam int LIMIT = 20000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] max_score;
  logic [31:0] max_row;
  logic [3:0]  max_col;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] mem_w [0:N-1][0:15];

  dna_matrix_reader_if bus ();

  dna_matrix_reader #(
    .addr_start_matrix(START),
    .addr_end_matrix  (END),
    .ROW_WORDS        (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start_i),
    .bus        (bus),
    .busy_o     (busy),
    .done_o     (done),
    .max_score_o(max_score),
    .max_row_o  (max_row),
    .max_col_o  (max_col)
  );

  always #5 clk = ~clk;

  // Registered-read memory; outside a read the bus carries noise the reader must ignore.
  always @(posedge clk) begin
    for (int k = 0; k < 16; k++) begin
      if (bus.mem_rd_o && bus.mem_addr_o >= START && bus.mem_addr_o <= END)
        bus.mem_row_i[32*k +: 32] <= mem_w[int'(bus.mem_addr_o) - START][k];
      else
        bus.mem_row_i[32*k +: 32] <= $urandom;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fill(input int mode);
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < 16; c++) begin
        case (mode)
          0: mem_w[r][c] = 32'(r * 16 + c);
          1: mem_w[r][c] = 32'hFFFF_FFFB;
          2: mem_w[r][c] = 32'd0;
          3: mem_w[r][c] = $urandom;
          default: mem_w[r][c] = $urandom | 32'h8000_0000;
        endcase
      end
    end
    if (mode == 1) mem_w[3][7] = 32'hFFFF_FFFF;
    if (mode == 2) begin
      mem_w[2][9]  = 32'd100;
      mem_w[2][4]  = 32'd100;
      mem_w[20][0] = 32'd100;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " mem_rd"},   {31'd0, bus.mem_rd_o}, 32'd0);
    check({tag, " mem_addr"}, bus.mem_addr_o, 32'(START));
    check({tag, " valid"},    {31'd0, bus.out_valid_o}, 32'd0);
    check({tag, " last"},     {31'd0, bus.out_last_o}, 32'd0);
    check({tag, " data"},     bus.out_data_o, 32'd0);
    check({tag, " busy"},     {31'd0, busy}, 32'd0);
    check({tag, " done"},     {31'd0, done}, 32'd0);
    check({tag, " max_score"}, max_score, 32'h8000_0000);
    check({tag, " max_row"},  max_row, 32'd0);
    check({tag, " max_col"},  {28'd0, max_col}, 32'd0);
  endtask

  // One full readout from a start pulse; rnd_ready toggles backpressure, poke_row pulses start mid-row.
  task automatic run_readout(input bit rnd_ready, input int poke_row, input string tag);
    logic [31:0] exp_q[$];
    logic [31:0] em;
    logic [31:0] er;
    logic [3:0]  ec;
    logic [31:0] held_data;
    logic        held_last;
    bit          stalled;
    bit          fin;
    bit          poked;
    int          got;
    int          dones;
    int          cyc;
    int          done_at;

    em = 32'h8000_0000; er = '0; ec = '0;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < 16; c++) begin
        exp_q.push_back(mem_w[r][c]);
        if ($signed(mem_w[r][c]) > $signed(em)) begin
          em = mem_w[r][c];
          er = 32'(r + START);
          ec = 4'(c);
        end
      end
    end

    stalled = 0; fin = 0; poked = 0; got = 0; dones = 0; done_at = -1;
    held_data = '0; held_last = 0;

    @(negedge clk);
    start_i = 1'b1;
    bus.out_ready_i = 1'b1;
    @(posedge clk);
    cyc = 0;
    while (cyc < LIMIT && !fin) begin
      @(negedge clk);
      start_i = 1'b0;
      if (stalled) begin
        check({tag, " stall data"}, bus.out_data_o, held_data);
        check({tag, " stall last"}, {31'd0, bus.out_last_o}, {31'd0, held_last});
      end
      bus.out_ready_i = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      stalled = 0;
      if (bus.out_valid_o) begin
        if (bus.out_ready_i) begin
          if (got < WORDS) begin
            check({tag, " word"}, bus.out_data_o, exp_q[got]);
            check({tag, " last"}, {31'd0, bus.out_last_o}, {31'd0, got == WORDS - 1});
          end
          got++;
        end else begin
          stalled = 1;
          held_data = bus.out_data_o;
          held_last = bus.out_last_o;
        end
        if (poke_row >= 0 && !poked && (got / 16) == poke_row) begin
          start_i = 1'b1;
          poked = 1;
        end
      end
      if (done) begin
        dones++;
        done_at = cyc + 1;
        fin = 1;
      end else begin
        @(posedge clk);
        cyc++;
      end
    end
    start_i = 1'b0;

    check({tag, " finished"}, {31'd0, fin}, 32'd1);
    check({tag, " word count"}, 32'(got), 32'(WORDS));
    if (!rnd_ready) check({tag, " done cycle"}, 32'(done_at), 32'(18 * N + 1));
    check({tag, " max_score"}, max_score, em);
    check({tag, " max_row"}, max_row, er);
    check({tag, " max_col"}, {28'd0, max_col}, {28'd0, ec});

    @(posedge clk);
    @(negedge clk);
    if (done) dones++;
    check({tag, " single done"}, 32'(dones), 32'd1);
    check({tag, " busy after"}, {31'd0, busy}, 32'd0);
    check({tag, " max hold"}, max_score, em);
    if (poke_row >= 0) check({tag, " start poked"}, {31'd0, poked}, 32'd1);
  endtask

  initial begin : main
    bit found;
    bus.out_ready_i = 1'b0;
    fill(0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle busy", {31'd0, busy}, 32'd0);

    fill(0);
    run_readout(1'b0, -1, "inc");
    check("inc max value", max_score, 32'd495);

    fill(0);
    run_readout(1'b1, -1, "bp");

    fill(1);
    run_readout(1'b1, -1, "neg");
    check("neg max value", max_score, 32'hFFFF_FFFF);

    fill(2);
    run_readout(1'b0, -1, "ties");
    check("ties max_row", max_row, 32'd2);

    fill(3);
    run_readout(1'b0, 5, "poke");

    // Abort in the WAIT cycle of row 10, then restart from scratch.
    fill(0);
    @(negedge clk);
    start_i = 1'b1;
    bus.out_ready_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    found = 0;
    for (int i = 0; i < LIMIT && !found; i++) begin
      if (bus.mem_rd_o && bus.mem_addr_o == 32'(START + 10)) found = 1;
      else @(negedge clk);
    end
    check("rst reached row 10", {31'd0, found}, 32'd1);
    check("rst max before abort", {31'd0, max_score == 32'h8000_0000}, 32'd0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post rst mem_rd", {31'd0, bus.mem_rd_o}, 32'd0);
    check("post rst busy", {31'd0, busy}, 32'd0);
    check("post rst valid", {31'd0, bus.out_valid_o}, 32'd0);

    fill(4);
    run_readout(1'b1, -1, "restart");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dna_matrix_reader.md
Name: dna_matrix_reader

Overview:
- Drains the score-matrix memory that the DNA systolic array fills: one row of 16 x 32-bit PE scores per matrix address.
- Reads rows from addr_start_matrix through addr_end_matrix, serialises each row onto a 32-bit valid/ready stream for the AXI-Lite/host side, and tracks the maximum signed score with its row/column position.
- Sits between the matrix memory read port and the host-readout logic. Started once the array reports matrix_full.

Parameters:
- addr_start_matrix, 0, first matrix row address read.
- addr_end_matrix, 30, last matrix row address read; must be >= addr_start_matrix (elaboration-time check).
- ROW_WORDS, 16, 32-bit scores per row (fixed 16; word index 4 bits).

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start_i  in  1  single-cycle start pulse; ignored while busy_o=1
- mem_rd_o  out  1  one-cycle read strobe to matrix memory
- mem_addr_o  out  32  matrix row address
- mem_row_i  in  512  row data, word k at bits [32k+31:32k]; valid the cycle after mem_rd_o
- out_data_o  out  32  current score word
- out_valid_o  out  1  out_data_o valid
- out_ready_i  in  1  consumer accepts when out_valid_o & out_ready_i
- out_last_o  out  1  high with word 15 of the last row
- busy_o  out  1  high from the cycle after start is accepted until DONE exits
- done_o  out  1  one-cycle pulse at end of readout
- max_score_o  out  32  largest signed score accepted on the stream
- max_row_o  out  32  row address holding max_score_o
- max_col_o  out  4  word index holding max_score_o

Behaviour:
- Reset (rst_n=0, async): state IDLE. mem_rd_o=0, mem_addr_o=addr_start_matrix, out_valid_o=0, out_last_o=0, out_data_o=0, busy_o=0, done_o=0, max_score_o=32'h8000_0000, max_row_o=0, max_col_o=0, word index=0, row buffer=0.
- Reset mid-operation aborts immediately. No pending read is honoured after release. A new start_i is required.
- FSM IDLE -> REQ -> WAIT -> SEND -> (REQ | DONE) -> IDLE.
- IDLE: on start_i=1 at edge T, load mem_addr_o=addr_start_matrix, reset max registers to reset values, go to REQ.
- REQ (cycle T+1): mem_rd_o=1 for exactly one cycle, busy_o=1, then go to WAIT.
- WAIT (T+2): mem_row_i is valid this cycle. Capture it into the row buffer at the end of the cycle, clear word index, then go to SEND.
- SEND (from T+3): out_valid_o=1, out_data_o=buffer[word index].
  - On handshake the word index increments.
  - If out_valid_o=1 and out_ready_i=0, out_data_o and out_last_o are held stable.
  - On handshake of word 15: if mem_addr_o==addr_end_matrix go to DONE; else mem_addr_o+1, go to REQ.
  - out_valid_o drops in the cycle after the last handshake of a row (no bubble-free row chaining).
- DONE: done_o=1 for one cycle, busy_o=1, then IDLE with busy_o=0. Max outputs hold until the next start.
- Max tracking, evaluated on every handshake:
  - if signed(out_data_o) > signed(max_score_o), load the word's value, row address and word index.
  - Ties keep the earliest (lower row, then lower column).
- Throughput with out_ready_i held at 1: 18 cycles per row. Total from start edge to done_o = 18*N+1 cycles, where N = addr_end_matrix - addr_start_matrix + 1 (default N=31 -> done_o at T+559).
- start_i while busy_o=1 or in DONE: ignored, no effect on state or max registers.
- out_ready_i high while out_valid_o=0: no effect.
- mem_row_i is only sampled in WAIT. Changes at other times are ignored.

Test Plan:
- Reset, then start with ready=1 and rows k filled with word j = k*16+j -> 496 words emitted in order 0..495; out_last_o only with 495; done_o at T+559; max_score_o=495, max_row_o=30, max_col_o=15.
- Backpressure: toggle out_ready_i pseudo-randomly -> out_data_o stable across every stall; no word lost or duplicated; same 0..495 sequence.
- Negative scores: all words = -5 except row 3 word 7 = -1 -> max_score_o=32'hFFFF_FFFF, max_row_o=3, max_col_o=7.
- Ties: value 100 at (row 2, col 9) and (row 2, col 4) and (row 20, col 0), all else 0 -> max_row_o=2, max_col_o=4.
- start_i pulsed during SEND of row 5 -> ignored; readout completes unchanged, single done_o.
- rst_n asserted during WAIT of row 10 -> all outputs return to reset values asynchronously. A fresh start_i after release restarts from addr_start_matrix with max_score_o re-initialised.
